// File: rtl/weight_update_seq.sv
// weight_update_seq: sequences one update sweep over a stored weight array through an external update stage.
module weight_update_seq #(
    parameter int N_WEIGHTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic             wus_clk,
    input  logic             wus_rst_n,
    input  logic             wus_start,
    input  logic [31:0]      wus_bp,
    input  logic [31:0]      wus_tm,
    input  logic [31:0]      wus_td,
    input  logic             wus_ld_en,
    input  logic [IDX_W-1:0] wus_ld_idx,
    input  logic [31:0]      wus_ld_w,
    input  logic [IDX_W-1:0] wus_rd_idx,
    output logic [31:0]      wus_rd_w,
    output logic [31:0]      wus_bpt_w,
    output logic [31:0]      wus_bpt_bp,
    output logic [31:0]      wus_bpt_tm,
    output logic [31:0]      wus_bpt_td,
    input  logic [31:0]      wus_bpt_wn,
    output logic             wus_busy,
    output logic             wus_done,
    output logic             wus_err
);
    typedef enum logic [1:0] {IDLE, PRESENT, CAPTURE, DONE} state_t;
    state_t state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [31:0] w_mem [N_WEIGHTS];
    logic accept, last;
    assign wus_rd_w = w_mem[wus_rd_idx];
    assign last = idx == IDX_W'(N_WEIGHTS - 1);
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                accept   = wus_start;
                state_nx = !wus_start ? IDLE : (wus_td == '0) ? DONE : PRESENT;
            end
            PRESENT: state_nx = CAPTURE;
            CAPTURE: state_nx = last ? DONE : PRESENT;
            default: state_nx = IDLE;
        endcase
        wus_busy = state != IDLE;
        wus_done = state == DONE;
    end
    always_ff @(posedge wus_clk) begin
        if (!wus_rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            wus_bpt_w  <= '0;
            wus_bpt_bp <= '0;
            wus_bpt_tm <= '0;
            wus_bpt_td <= '0;
            wus_err    <= 1'b0;
            for (int i = 0; i < N_WEIGHTS; i++) w_mem[i] <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                wus_bpt_bp <= wus_bp;
                wus_bpt_tm <= wus_tm;
                wus_bpt_td <= wus_td;
                wus_err    <= wus_td == '0;
                idx        <= '0;
            end
            // a load in the start cycle lands before PRESENT reads it
            if (state == IDLE && wus_ld_en) w_mem[wus_ld_idx] <= wus_ld_w;
            if (state == PRESENT) wus_bpt_w <= w_mem[idx];
            if (state == CAPTURE) begin
                w_mem[idx] <= wus_bpt_wn;
                if (!last) idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_weight_update_seq.sv
// tb_weight_update_seq: randomized self-checking bench against a sweep-level reference model.
module tb_weight_update_seq;
    localparam int N  = 4;
    localparam int IW = 2;
    logic          wus_clk, wus_rst_n, wus_start, wus_ld_en;
    logic [31:0]   wus_bp, wus_tm, wus_td, wus_ld_w, wus_rd_w;
    logic [31:0]   wus_bpt_w, wus_bpt_bp, wus_bpt_tm, wus_bpt_td, wus_bpt_wn;
    logic [IW-1:0] wus_ld_idx, wus_rd_idx;
    logic          wus_busy, wus_done, wus_err;
    int            vectors = 0, errors = 0;
    logic [31:0]   mw [N];
    logic [31:0]   mbp, mtm, mtd;
    logic          merr;

    weight_update_seq #(.N_WEIGHTS(N), .IDX_W(IW)) dut (
        .wus_clk(wus_clk), .wus_rst_n(wus_rst_n), .wus_start(wus_start),
        .wus_bp(wus_bp), .wus_tm(wus_tm), .wus_td(wus_td),
        .wus_ld_en(wus_ld_en), .wus_ld_idx(wus_ld_idx), .wus_ld_w(wus_ld_w),
        .wus_rd_idx(wus_rd_idx), .wus_rd_w(wus_rd_w),
        .wus_bpt_w(wus_bpt_w), .wus_bpt_bp(wus_bpt_bp), .wus_bpt_tm(wus_bpt_tm),
        .wus_bpt_td(wus_bpt_td), .wus_bpt_wn(wus_bpt_wn),
        .wus_busy(wus_busy), .wus_done(wus_done), .wus_err(wus_err)
    );

    // update stage stand-in
    assign wus_bpt_wn = wus_bpt_w + wus_bpt_bp;

    initial wus_clk = 1'b0;
    always #5 wus_clk = ~wus_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wus_clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_bpt_bp"}, wus_bpt_bp, mbp);
        chk({tag, "_bpt_tm"}, wus_bpt_tm, mtm);
        chk({tag, "_bpt_td"}, wus_bpt_td, mtd);
        chk({tag, "_err"}, 32'(wus_err), 32'(merr));
        for (int i = 0; i < N; i++) begin
            wus_rd_idx = IW'(i);
            #1;
            chk({tag, "_w"}, wus_rd_w, mw[i]);
        end
    endtask

    task automatic load(input int i, input logic [31:0] w);
        wus_ld_en = 1'b1; wus_ld_idx = IW'(i); wus_ld_w = w;
        tick();
        wus_ld_en = 1'b0;
        mw[i] = w;
    endtask

    task automatic sweep(input logic [31:0] bp, input logic [31:0] tm, input logic [31:0] td,
                         input bit ld, input int li, input logic [31:0] lw, input bit inj);
        int dc;
        wus_start = 1'b1; wus_bp = bp; wus_tm = tm; wus_td = td;
        wus_ld_en = ld; wus_ld_idx = IW'(li); wus_ld_w = lw;
        tick();
        wus_start = 1'b0; wus_ld_en = 1'b0;
        wus_bp = $urandom; wus_tm = $urandom; wus_td = $urandom;
        if (ld) mw[li] = lw;
        dc = (td == 0) ? 1 : 2 * N + 1;
        for (int c = 1; c <= dc + 1; c++) begin
            chk("busy", 32'(wus_busy), 32'(c <= dc));
            chk("done", 32'(wus_done), 32'(c == dc));
            if (td != 0 && c % 2 == 0 && c <= 2 * N) chk("bpt_w", wus_bpt_w, mw[c/2-1]);
            if (inj && c == 3) wus_start = 1'b1;
            if (inj && c == 4) begin
                wus_start = 1'b0; wus_ld_en = 1'b1; wus_ld_idx = 2; wus_ld_w = 99;
            end
            if (inj && c == 5) wus_ld_en = 1'b0;
            if (c <= dc) tick();
        end
        if (td != 0) for (int i = 0; i < N; i++) mw[i] = mw[i] + bp;
        merr = td == 0; mbp = bp; mtm = tm; mtd = td;
        check_state("sweep");
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) mw[i] = '0;
        mbp = '0; mtm = '0; mtd = '0; merr = 1'b0;
    endtask

    initial begin
        int c, nd, last_done;
        wus_rst_n = 1'b0; wus_start = 1'b0; wus_ld_en = 1'b0;
        wus_bp = '0; wus_tm = '0; wus_td = '0; wus_ld_idx = '0; wus_ld_w = '0; wus_rd_idx = '0;
        clear_model();
        tick(); tick();
        wus_rst_n = 1'b1;
        chk("rst_busy", 32'(wus_busy), 0);
        chk("rst_done", 32'(wus_done), 0);
        chk("rst_bpt_w", wus_bpt_w, 0);
        check_state("rst");

        for (int i = 0; i < N; i++) load(i, 32'(10 * (i + 1)));
        sweep(5, 1, 1, 0, 0, 0, 0);
        chk("req21_w3", mw[3], 45);

        for (int i = 0; i < N; i++) load(i, 32'(i + 1));
        sweep(7, 3, 0, 0, 0, 0, 0);
        sweep(2, 1, 1, 0, 0, 0, 0);

        sweep(32'd100, 9, 4, 0, 0, 0, 1);

        sweep(32'hFFFF_FFFF, 1, 1, 1, 0, 7, 0);
        wus_rd_idx = 0;
        #1;
        chk("req24_w0", wus_rd_w, 6);

        // reset in the fifth sweep cycle, colliding with start and load
        wus_start = 1'b1; wus_bp = 3; wus_tm = 1; wus_td = 1;
        tick();
        wus_start = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        wus_rst_n = 1'b0; wus_start = 1'b1; wus_ld_en = 1'b1; wus_ld_idx = 1; wus_ld_w = 55;
        tick();
        wus_rst_n = 1'b1; wus_start = 1'b0; wus_ld_en = 1'b0;
        clear_model();
        chk("rstmid_busy", 32'(wus_busy), 0);
        chk("rstmid_done", 32'(wus_done), 0);
        chk("rstmid_bpt_w", wus_bpt_w, 0);
        check_state("rstmid");
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            nd += int'(wus_done);
            tick();
        end
        chk("rstmid_nodone", 32'(nd), 0);

        // start held high: sweeps repeat with one IDLE cycle between
        for (int i = 0; i < N; i++) load(i, $urandom);
        wus_start = 1'b1; wus_bp = 11; wus_tm = 2; wus_td = 3;
        nd = 0; last_done = 0; c = 0;
        while (nd < 3 && c < 60) begin
            tick();
            c++;
            if (wus_done) begin
                nd++;
                chk("b2b_done_at", 32'(c), 32'(nd == 1 ? 2 * N + 1 : last_done + 2 * N + 2));
                last_done = c;
                if (nd == 3) wus_start = 1'b0;
            end
        end
        chk("b2b_count", 32'(nd), 3);
        tick();
        chk("b2b_idle", 32'(wus_busy), 0);
        for (int i = 0; i < N; i++) mw[i] = mw[i] + 33;
        mbp = 11; mtm = 2; mtd = 3; merr = 1'b0;
        check_state("b2b");

        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 1) == 1) load($urandom_range(0, N - 1), $urandom);
            sweep($urandom, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, N - 1), $urandom,
                  $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
